// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU issue sequencer
package alu_seq_pkg;

  localparam int INSTR_W  = 16;
  localparam int CLS_HI   = 15;
  localparam int CLS_LO   = 14;
  localparam int RD_HI    = 13;
  localparam int RD_LO    = 11;
  localparam int RS1_HI   = 10;
  localparam int RS1_LO   = 8;
  localparam int RS2_HI   = 7;
  localparam int RS2_LO   = 5;
  localparam int SHAMT_HI = 3;
  localparam int SHAMT_LO = 0;
  localparam int OFFL_HI  = 4;

  typedef enum logic [1:0] {
    CLS_ADD  = 2'b00,
    CLS_SUB  = 2'b01,
    CLS_SLLI = 2'b10,
    CLS_BEQ  = 2'b11
  } cls_t;

  localparam logic [1:0] ALUOP_ADD  = 2'b10;
  localparam logic [1:0] ALUOP_SUB  = 2'b11;
  localparam logic [1:0] ALUOP_SLLI = 2'b01;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ_A = 3'd1,
    READ_B = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational field split of the latched instruction
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output cls_t               cls,
  output logic [2:0]         rd,
  output logic [2:0]         rs1,
  output logic [2:0]         rs2,
  output logic [3:0]         shamt,
  output logic [DATA_W-1:0]  offset
);

  logic [7:0] off8;

  always_comb begin
    cls    = cls_t'(instr[CLS_HI:CLS_LO]);
    rd     = instr[RD_HI:RD_LO];
    rs1    = instr[RS1_HI:RS1_LO];
    rs2    = instr[RS2_HI:RS2_LO];
    shamt  = instr[SHAMT_HI:SHAMT_LO];
    // Branch offset borrows the rd field as its upper three bits.
    off8   = {instr[RD_HI:RD_LO], instr[OFFL_HI:0]};
    offset = {{(DATA_W-8){off8[7]}}, off8};
  end

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - five-cycle issue sequencer: fetch operands, drive ALU, write back or branch
module alu_issue_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_offset,
  output logic              flag_z
);

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              flag_z_q, flag_z_d;

  cls_t              cls;
  logic [2:0]        rd, rs1, rs2;
  logic [3:0]        shamt;
  logic [DATA_W-1:0] offset;

  alu_seq_decode #(.DATA_W(DATA_W)) u_decode (
    .instr  (instr_q),
    .cls    (cls),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .shamt  (shamt),
    .offset (offset)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    opa_d       = opa_q;
    res_d       = res_q;
    flag_z_d    = flag_z_q;
    instr_ready = 1'b0;
    rf_raddr    = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ALUOP_ADD;
    br_taken    = 1'b0;
    br_offset   = '0;

    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = READ_A;
        end
      end
      READ_A: begin
        rf_raddr = rs1;
        state_d  = READ_B;
      end
      READ_B: begin
        rf_raddr = rs2;
        opa_d    = rf_rdata;
        state_d  = EXEC;
      end
      EXEC: begin
        // rf_rdata now carries rs2; opA holds rs1.
        case (cls)
          CLS_ADD: begin
            alu_a  = opa_q;
            alu_b  = rf_rdata;
            alu_op = ALUOP_ADD;
          end
          CLS_SLLI: begin
            alu_a  = opa_q;
            alu_b  = {{(DATA_W-4){1'b0}}, shamt};
            alu_op = ALUOP_SLLI;
          end
          default: begin
            alu_a  = rf_rdata;
            alu_b  = opa_q;
            alu_op = ALUOP_SUB;
          end
        endcase
        res_d    = alu_result;
        flag_z_d = alu_zero;
        state_d  = WB;
      end
      WB: begin
        if (cls == CLS_BEQ) begin
          br_taken  = flag_z_q;
          br_offset = offset;
        end else if (rd != '0) begin
          rf_we    = 1'b1;
          rf_waddr = rd;
          rf_wdata = res_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset squashes any in-flight side effect in the cycle it is asserted.
    if (rst) begin
      instr_ready = 1'b0;
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      br_taken    = 1'b0;
      br_offset   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      opa_q    <= '0;
      res_q    <= '0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      opa_q    <= opa_d;
      res_q    <= res_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign flag_z = flag_z_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - randomized and directed bench with ALU, register file and reference model
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        alu_zero;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        flag_z;

  always #5 clk = ~clk;

  alu_issue_seq #(.DATA_W(16), .REG_AW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .flag_z      (flag_z)
  );

  // ALU
  always_comb begin
    case (alu_op)
      2'b10:   alu_result = alu_a + alu_b;
      2'b11:   alu_result = alu_b - alu_a;
      2'b01:   alu_result = alu_a << alu_b;
      default: alu_result = 16'h0;
    endcase
    alu_zero = (alu_result == 16'h0);
  end

  // Register file: synchronous read, r0 hard-wired to zero, bench preload port
  logic [15:0] rf_mem [8];
  logic        pl_we = 1'b0;
  logic [2:0]  pl_addr = 3'd0;
  logic [15:0] pl_data = 16'h0;

  always @(posedge clk) begin
    rf_rdata <= (rf_raddr == 3'd0) ? 16'h0 : rf_mem[rf_raddr];
    if (pl_we && pl_addr != 3'd0) rf_mem[pl_addr] <= pl_data;
    else if (rf_we && rf_waddr != 3'd0) rf_mem[rf_waddr] <= rf_wdata;
  end

  logic [15:0] mregs [8];
  logic        prev_z;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] cls, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [4:0] lo);
    return {cls, rd, rs1, rs2, lo};
  endfunction

  task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = r; pl_data = v;
    @(negedge clk);
    pl_we = 1'b0;
    if (r != 3'd0) mregs[r] = v;
  endtask

  task automatic issue(input logic [15:0] ins);
    logic [1:0]  cls;
    logic [2:0]  rd, rs1, rs2;
    logic [3:0]  sh;
    logic [7:0]  off8;
    logic [15:0] a, b, res, ea, eb, eoff;
    logic [1:0]  eop;
    logic        ez, ewe, ebr;
    int          waited;
    cls = ins[15:14]; rd = ins[13:11]; rs1 = ins[10:8]; rs2 = ins[7:5]; sh = ins[3:0];
    off8 = {ins[13:11], ins[4:0]};
    eoff = {{8{off8[7]}}, off8};
    a = mregs[rs1];
    b = mregs[rs2];
    case (cls)
      2'b00:   begin res = a + b;  ea = a; eb = b;           eop = 2'b10; end
      2'b10:   begin res = a << sh; ea = a; eb = {12'h0, sh}; eop = 2'b01; end
      default: begin res = a - b;  ea = b; eb = a;           eop = 2'b11; end
    endcase
    ez  = (res == 16'h0);
    ewe = (cls != 2'b11) && (rd != 3'd0);
    ebr = (cls == 2'b11) && ez;

    waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      check_eq("ready_timeout", 32'(instr_ready), 32'd1);
      return;
    end
    instr = ins; instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);

    @(negedge clk);
    check_eq("c1_raddr", 32'(rf_raddr), 32'(rs1));
    check_eq("c1_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    check_eq("c2_raddr", 32'(rf_raddr), 32'(rs2));
    check_eq("c2_flag_hold", 32'(flag_z), 32'(prev_z));
    @(negedge clk);
    check_eq("c3_alu_op", 32'(alu_op), 32'(eop));
    check_eq("c3_alu_a", 32'(alu_a), 32'(ea));
    check_eq("c3_alu_b", 32'(alu_b), 32'(eb));
    check_eq("c3_we_low", 32'(rf_we), 32'd0);
    @(negedge clk);
    check_eq("c4_we", 32'(rf_we), 32'(ewe));
    if (ewe) begin
      check_eq("c4_waddr", 32'(rf_waddr), 32'(rd));
      check_eq("c4_wdata", 32'(rf_wdata), 32'(res));
    end
    check_eq("c4_br", 32'(br_taken), 32'(ebr));
    if (cls == 2'b11) check_eq("c4_broff", 32'(br_offset), 32'(eoff));
    check_eq("c4_flag_z", 32'(flag_z), 32'(ez));
    check_eq("c4_op_idle", 32'(alu_op), 32'h2);
    @(negedge clk);
    check_eq("c5_ready", 32'(instr_ready), 32'd1);
    check_eq("c5_we", 32'(rf_we), 32'd0);
    check_eq("c5_br", 32'(br_taken), 32'd0);
    check_eq("c5_flag_z", 32'(flag_z), 32'(ez));
    if (ewe) mregs[rd] = res;
    prev_z = ez;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, wes;
    logic [15:0] keep;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    prev_z = 1'b0;
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0;

    // Clear the register file through the preload port while in reset
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      pl_we = 1'b1; pl_addr = 3'(i); pl_data = 16'h0;
    end
    @(negedge clk);
    pl_we = 1'b0;
    instr_valid = 1'b1;
    check_eq("rst_ready", 32'(instr_ready), 32'd0);
    check_eq("rst_we", 32'(rf_we), 32'd0);
    check_eq("rst_br", 32'(br_taken), 32'd0);
    instr_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_ready", 32'(instr_ready), 32'd1);
    check_eq("post_rst_flag", 32'(flag_z), 32'd0);
    check_eq("post_rst_raddr", 32'(rf_raddr), 32'd0);
    check_eq("post_rst_aluop", 32'(alu_op), 32'h2);
    check_eq("post_rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("post_rst_alu_b", 32'(alu_b), 32'd0);
    check_eq("post_rst_wdata", 32'(rf_wdata), 32'd0);
    check_eq("post_rst_waddr", 32'(rf_waddr), 32'd0);
    check_eq("post_rst_broff", 32'(br_offset), 32'd0);

    // Directed cases
    set_reg(3'd1, 16'd5); set_reg(3'd2, 16'd3);
    issue(mk(2'b00, 3'd3, 3'd1, 3'd2, 5'd0));
    set_reg(3'd1, 16'd3); set_reg(3'd2, 16'd5);
    issue(mk(2'b01, 3'd4, 3'd1, 3'd2, 5'd0));
    set_reg(3'd1, 16'd7); set_reg(3'd2, 16'd7);
    issue(mk(2'b01, 3'd4, 3'd1, 3'd2, 5'd0));
    set_reg(3'd1, 16'h8001);
    issue(mk(2'b10, 3'd5, 3'd1, 3'd0, 5'd1));
    set_reg(3'd1, 16'h0001);
    issue(mk(2'b10, 3'd5, 3'd1, 3'd0, 5'd15));
    set_reg(3'd1, 16'd9); set_reg(3'd2, 16'd9);
    issue(mk(2'b11, 3'b111, 3'd1, 3'd2, 5'b11100));
    set_reg(3'd2, 16'd8);
    issue(mk(2'b11, 3'b111, 3'd1, 3'd2, 5'b11100));

    // ADD r0 with instr_valid held high: one accept per five cycles, no write-back
    set_reg(3'd1, 16'd5); set_reg(3'd2, 16'd3);
    @(negedge clk);
    instr = mk(2'b00, 3'd0, 3'd1, 3'd2, 5'd0);
    instr_valid = 1'b1;
    acc = 0; wes = 0;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) @(negedge clk);
      if (instr_valid && instr_ready) acc++;
      if (rf_we) wes++;
    end
    instr_valid = 1'b0;
    check_eq("b2b_accepts", 32'(acc), 32'd5);
    check_eq("b2b_no_we", 32'(wes), 32'd0);
    prev_z = ((mregs[1] + mregs[2]) == 16'h0);

    // Reset during EXEC of ADD r3 discards it
    keep = mregs[3];
    @(negedge clk);
    instr = mk(2'b00, 3'd3, 3'd1, 3'd2, 5'd0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstx_we", 32'(rf_we), 32'd0);
    check_eq("rstx_br", 32'(br_taken), 32'd0);
    check_eq("rstx_ready", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstx_ready_after", 32'(instr_ready), 32'd1);
    check_eq("rstx_we_after", 32'(rf_we), 32'd0);
    check_eq("rstx_r3_kept", 32'(rf_mem[3]), 32'(keep));
    prev_z = 1'b0;
    issue(mk(2'b00, 3'd3, 3'd1, 3'd2, 5'd0));

    // Randomized instructions with small operand values so BEQ sometimes hits
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        set_reg(3'($urandom_range(1, 7)),
                ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom));
      issue(16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
